// File: rtl/pwm_multi.sv
// ---------------------------------------------------------------------------
// pwm_multi
// Multi-channel PWM generator. One shared period counter feeds CHANNELS
// compare outputs. Duty writes land in a shadow register per channel and are
// copied to the active register only at a period boundary, so a running
// period is never disturbed. Edge-aligned and center-aligned counting are
// supported, plus a per-channel output inversion.
//
// Ports:
//   clk          clock
//   reset        asynchronous, active-high; clears all state
//   enable       1 = run; 0 = counter held at 0, outputs at inactive level
//   center_mode  0 = edge-aligned, 1 = center-aligned (taken at boundary)
//   polarity     per-channel invert, 1 = active-low
//   duty_wr      one-cycle write strobe
//   duty_ch      channel index of the write (out-of-range index ignored)
//   duty_data    duty value to write
//   period_tick  one-cycle pulse following each active-register load
//   pwm_out      registered PWM outputs
// ---------------------------------------------------------------------------
module pwm_multi #(
    parameter int CLK_FREQ = 27_000_000,
    parameter int PWM_FREQ = 1000,
    parameter int CHANNELS = 4,
    parameter int DUTY_W   = 8,
    // Channel-index width; may be widened so out-of-range indices are
    // expressible on the port.
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                center_mode,
    input  logic [CHANNELS-1:0] polarity,
    input  logic                duty_wr,
    input  logic [CH_W-1:0]     duty_ch,
    input  logic [DUTY_W-1:0]   duty_data,
    output logic                period_tick,
    output logic [CHANNELS-1:0] pwm_out
);

    localparam int PERIOD = CLK_FREQ / PWM_FREQ;
    localparam int CMAX   = PERIOD / 2;
    localparam int CNT_W  = $clog2(PERIOD);
    localparam int PROD_W = DUTY_W + CNT_W + 1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [CNT_W-1:0]                cnt_q, cnt_d;
    dir_t                            dir_q, dir_d;
    logic [CHANNELS-1:0][DUTY_W-1:0] shadow_q, shadow_d;
    logic [CHANNELS-1:0][DUTY_W-1:0] active_q, active_d;
    logic                            mode_q, mode_d;
    logic                            tick_q, tick_d;
    logic [CHANNELS-1:0]             pwm_q, pwm_d;

    logic                            boundary;
    logic                            mode_eff;
    logic [CHANNELS-1:0][DUTY_W-1:0] active_eff;
    logic [CHANNELS-1:0]             raw;

    // Compare one channel's duty against the counter. All-ones duty is
    // forced fully on, since the scaled threshold would fall one step short.
    function automatic logic duty_raw(input logic [DUTY_W-1:0] duty,
                                      input logic              center,
                                      input logic [CNT_W-1:0]  cnt);
        logic [PROD_W-1:0] scale;
        logic [PROD_W-1:0] thr;
        scale = center ? PROD_W'(CMAX) : PROD_W'(PERIOD);
        thr   = (PROD_W'(duty) * scale) >> DUTY_W;
        return (&duty) || (PROD_W'(cnt) < thr);
    endfunction

    // Start of period: counter at 0 on the way up while running. Enabling
    // always starts from this state, so the first enabled cycle is a boundary.
    assign boundary = enable && (cnt_q == '0) && (dir_q == DIR_UP);

    // In the boundary cycle the values being loaded already govern the
    // output, so every period is built from one consistent duty and mode.
    assign mode_eff   = boundary ? center_mode : mode_q;
    assign active_eff = boundary ? shadow_q : active_q;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            assign raw[gi] = duty_raw(active_eff[gi], mode_eff, cnt_q);
        end
    endgenerate

    always_comb begin
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        shadow_d = shadow_q;
        active_d = active_q;
        mode_d   = mode_q;
        tick_d   = 1'b0;
        pwm_d    = pwm_q;

        // Shadow writes are accepted regardless of enable.
        for (int i = 0; i < CHANNELS; i++) begin
            if (duty_wr && (duty_ch == CH_W'(i))) begin
                shadow_d[i] = duty_data;
            end
        end

        if (!enable) begin
            cnt_d = '0;
            dir_d = DIR_UP;
            pwm_d = polarity;
        end else begin
            if (boundary) begin
                active_d = shadow_q;
                mode_d   = center_mode;
                tick_d   = 1'b1;
            end

            pwm_d = raw ^ polarity;

            if (!mode_eff) begin
                dir_d = DIR_UP;
                cnt_d = (cnt_q == CNT_W'(PERIOD - 1)) ? '0 : cnt_q + 1'b1;
            end else if (dir_q == DIR_UP) begin
                // The top value is held for a second cycle as the ramp turns.
                if (cnt_q == CNT_W'(CMAX - 1)) begin
                    dir_d = DIR_DOWN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                // Zero is likewise repeated: last down cycle, then boundary.
                if (cnt_q == '0) begin
                    dir_d = DIR_UP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            dir_q    <= DIR_UP;
            shadow_q <= '0;
            active_q <= '0;
            mode_q   <= 1'b0;
            tick_q   <= 1'b0;
            pwm_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            mode_q   <= mode_d;
            tick_q   <= tick_d;
            pwm_q    <= pwm_d;
        end
    end

    assign period_tick = tick_q;
    assign pwm_out     = pwm_q;

endmodule

// File: tb/tb_pwm_multi.sv
// ---------------------------------------------------------------------------
// tb_pwm_multi
// Self-checking bench for pwm_multi with PERIOD = 10, CMAX = 5, 4 channels,
// 8-bit duty and a 3-bit channel index. A reference model tracks the
// position inside the period and derives the expected outputs from the
// duty/threshold rules with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_pwm_multi;

    localparam int PERIOD = 10;
    localparam int CMAX   = 5;
    localparam int NCH    = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       center_mode;
    logic [3:0] polarity;
    logic       duty_wr;
    logic [2:0] duty_ch;
    logic [7:0] duty_data;
    logic       period_tick;
    logic [3:0] pwm_out;

    pwm_multi #(
        .CLK_FREQ (1000),
        .PWM_FREQ (100),
        .CHANNELS (4),
        .DUTY_W   (8),
        .CH_W     (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .center_mode (center_mode),
        .polarity    (polarity),
        .duty_wr     (duty_wr),
        .duty_ch     (duty_ch),
        .duty_data   (duty_data),
        .period_tick (period_tick),
        .pwm_out     (pwm_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int       m_pos;
    int       m_shadow [NCH];
    int       m_active [NCH];
    bit       m_center;
    bit [3:0] m_pwm;
    bit       m_tick;
    int       hi_cnt [NCH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected raw level for a duty at a position in the period.
    function automatic bit exp_level(input int duty, input bit center, input int pos);
        int cnt;
        int thr;
        cnt = center ? ((pos < CMAX) ? pos : 2 * CMAX - 1 - pos) : pos;
        thr = (duty * (center ? CMAX : PERIOD)) / 256;
        return (duty == 255) || (cnt < thr);
    endfunction

    // Advance the model by one clock using the inputs now being driven.
    task automatic model_cycle();
        if (reset) begin
            m_pos    = 0;
            m_center = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                m_shadow[i] = 0;
                m_active[i] = 0;
            end
            m_pwm  = '0;
            m_tick = 1'b0;
            return;
        end
        if (!enable) begin
            m_pos  = 0;
            m_pwm  = polarity;
            m_tick = 1'b0;
        end else begin
            m_tick = (m_pos == 0);
            if (m_pos == 0) begin
                m_active = m_shadow;
                m_center = center_mode;
            end
            for (int i = 0; i < NCH; i++) begin
                m_pwm[i] = exp_level(m_active[i], m_center, m_pos) ^ polarity[i];
            end
            m_pos = (m_pos + 1) % (m_center ? 2 * CMAX : PERIOD);
        end
        if (duty_wr && (int'(duty_ch) < NCH)) begin
            m_shadow[duty_ch] = int'(duty_data);
        end
    endtask

    task automatic step();
        model_cycle();
        @(posedge clk);
        #1;
        $display("cyc t=%0t en=%0b cm=%0b pol=%b wr=%0b ch=%0d d=%0d -> pwm=%b tick=%0b",
                 $time, enable, center_mode, polarity, duty_wr, duty_ch, duty_data,
                 pwm_out, period_tick);
        check("pwm_out", 32'(pwm_out), 32'(m_pwm));
        check("period_tick", 32'(period_tick), 32'(m_tick));
        for (int i = 0; i < NCH; i++) hi_cnt[i] += int'(pwm_out[i]);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic write(input int ch, input int data);
        duty_wr   = 1'b1;
        duty_ch   = 3'(ch);
        duty_data = 8'(data);
        step();
        duty_wr   = 1'b0;
    endtask

    task automatic clear_hi();
        for (int i = 0; i < NCH; i++) hi_cnt[i] = 0;
    endtask

    // Assert reset between edges and confirm the outputs drop without a clock.
    task automatic async_reset(input string tag);
        reset = 1'b1;
        #1;
        check(tag, 32'(pwm_out), 32'd0);
        step();
        reset = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        int r;
        reset       = 1'b1;
        enable      = 1'b0;
        center_mode = 1'b0;
        polarity    = 4'b0000;
        duty_wr     = 1'b0;
        duty_ch     = '0;
        duty_data   = '0;
        clear_hi();

        run(2);
        check("reset_pwm", 32'(pwm_out), 32'd0);
        check("reset_tick", 32'(period_tick), 32'd0);
        reset = 1'b0;

        // Edge mode with extremes on the other channels.
        write(0, 128);
        write(1, 0);
        write(2, 255);
        write(3, 1);
        enable = 1'b1;
        run(20);
        clear_hi();
        run(20);
        check("ch0_hi_edge", hi_cnt[0], 10);
        check("ch1_hi_zero", hi_cnt[1], 0);
        check("ch2_hi_full", hi_cnt[2], 20);
        check("ch3_hi_tiny", hi_cnt[3], 0);

        // Double buffering: mid-period write, then a write in a boundary cycle.
        run(3);
        write(0, 64);
        run(25);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = period_tick;
        end
        check("wait_tick", 32'(found), 32'd1);
        run(8);
        write(0, 200);   // lands in the boundary cycle
        run(25);

        // Center mode requested mid-period.
        run(4);
        center_mode = 1'b1;
        write(0, 128);
        run(30);
        clear_hi();
        run(20);
        check("ch0_hi_center", hi_cnt[0], 8);

        // Polarity with the block disabled, then re-enable.
        polarity = 4'b0001;
        enable   = 1'b0;
        run(2);
        check("disabled_pwm", 32'(pwm_out), 32'b0001);
        enable = 1'b1;
        step();
        check("reenable_tick", 32'(period_tick), 32'd1);
        write(5, 77);    // out-of-range channel
        run(20);

        // Reset while the ch0 pulse is active (active-low, so level 0).
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = (pwm_out[0] == 1'b0);
        end
        check("wait_ch0_active", 32'(found), 32'd1);
        async_reset("reset_mid_op");
        polarity = 4'b0000;
        enable   = 1'b1;
        clear_hi();
        run(20);
        check("post_reset_ch0_hi", hi_cnt[0], 0);

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 199));
            if (r < 40) begin
                case ($urandom_range(0, 4))
                    0:       write(int'($urandom_range(0, 7)), 0);
                    1:       write(int'($urandom_range(0, 7)), 255);
                    2:       write(int'($urandom_range(0, 7)), 1);
                    default: write(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
                endcase
            end else begin
                if (r == 50 || r == 51) enable = ~enable;
                if (r >= 60 && r <= 62) center_mode = ~center_mode;
                if (r == 70) polarity = 4'($urandom_range(0, 15));
                if (r == 199 && $urandom_range(0, 3) == 0) begin
                    async_reset("reset_random");
                end else begin
                    step();
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
Multi-channel PWM generator and the parametrised successor of the single-channel PWM block. One shared period counter drives CHANNELS independent compare outputs, each with configurable duty resolution. Duty updates are double-buffered so that changes only take effect at a period boundary. The block supports edge-aligned and center-aligned modes plus per-channel output polarity. It sits between the CPU register interface (duty writes) and the board LED/motor pins.

Parameters:
CLK_FREQ, 27_000_000, clk frequency in Hz
PWM_FREQ, 1000, PWM frequency in Hz (edge mode); PERIOD = CLK_FREQ / PWM_FREQ, truncated, must be >= 4
CHANNELS, 4, number of PWM outputs, 1..16
DUTY_W, 8, duty word width, 4..16

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high; clears all state
enable  in  1  1 = run; 0 = counter held, outputs at inactive level
center_mode  in  1  0 = edge-aligned, 1 = center-aligned; sampled only at period boundary
polarity  in  CHANNELS  per-channel output invert; bit = 1 means active-low
duty_wr  in  1  write strobe, one cycle, no backpressure
duty_ch  in  $clog2(CHANNELS) (min 1)  target channel of write
duty_data  in  DUTY_W  duty value to write
period_tick  out  1  one-cycle pulse on each active-register load
pwm_out  out  CHANNELS  registered PWM outputs

Behaviour:
- Reset (asynchronous, active-high) clears: counter = 0, direction = up, shadow[] = 0, active[] = 0, mode_q = edge, period_tick = 0, pwm_out = 0.
- Widths: counter uses $clog2(PERIOD) bits. Threshold products use DUTY_W + $clog2(PERIOD) + 1 bits. No overflow is allowed.
- Edge mode: counter runs 0..PERIOD-1, then wraps to 0.
  - thr = (active * PERIOD) >> DUTY_W.
  - raw = (counter < thr).
- Center mode: CMAX = PERIOD / 2.
  - Up phase: counter runs 0..CMAX-1. Down phase: counter runs CMAX-1..0 (each value appears twice). Period = 2*CMAX cycles.
  - thr = (active * CMAX) >> DUTY_W.
  - raw = (counter < thr), which gives a pulse of 2*thr cycles centered on the period boundary.
- Full scale: active == all-ones forces raw = 1 for the whole period in both modes. active == 0 gives raw = 0 for the whole period.
- Boundary: the cycle in which the counter is 0 and the direction is up (start of period).
  - At the boundary: active[i] <= shadow[i] for all channels, mode_q <= center_mode, and period_tick = 1 for that one cycle.
  - Any new mode takes effect from the next counter step.
- Writes: duty_wr with duty_ch < CHANNELS sets shadow[duty_ch] <= duty_data on the next edge. Writes with duty_ch >= CHANNELS are ignored.
- A write in the same cycle as a boundary load does not reach active in that load. It is applied at the following boundary.
- Output latency: pwm_out[i] <= raw[i] ^ polarity[i], one cycle after the counter value that produced raw. Polarity changes apply immediately (next edge), not at the boundary.
- enable = 0:
  - counter <= 0, direction <= up, period_tick = 0, pwm_out[i] <= polarity[i] (inactive level).
  - Shadow writes are still accepted.
- enable rising edge: the first enabled cycle is treated as a boundary (load active, sample mode, pulse period_tick).
- Reset mid-period: outputs go to 0 immediately (asynchronous). Shadow contents are lost.
- Mode switch mid-period: counter continues in the old mode until the boundary. No glitch, no truncated pulse.

Test Plan:
Use CLK_FREQ=1000, PWM_FREQ=100 (PERIOD=10, CMAX=5), DUTY_W=8, CHANNELS=4.
- Edge duty: ch0 = 128, enable, polarity = 0 -> ch0 high 5 cycles, low 5 cycles, repeating. period_tick every 10 cycles. Output lags the counter by 1 cycle.
- Extremes: ch1 = 0, ch2 = 255, ch3 = 1 -> ch1 constant 0, ch2 constant 1, ch3 constant 0 (thr = (1*10)>>8 = 0).
- Double buffering: write ch0 = 64 mid-period while active = 128 -> current period still has 5 high cycles, next period has 2 high cycles (thr = 2). A write on the period_tick cycle takes effect one period later.
- Center mode: set center_mode = 1 mid-period, ch0 = 128 -> switch happens at the next boundary. Then thr = 2, and ch0 is high for 4 cycles (2 at the end of the down ramp, 2 at the start of the up ramp), with period 10.
- Polarity/enable: polarity = 4'b0001, enable = 0 -> pwm_out = 0001. Re-enable -> period_tick on the first cycle and ch0 waveform inverted. duty_ch = 5 write (CHANNELS = 4 with 3-bit index override test) -> ignored.
- Reset mid-operation: assert reset while ch0 is high -> pwm_out = 0 immediately. After release with enable = 1, all outputs stay 0/inactive because active = 0.
